led_display_frame_swap_arbiter: RTL and testbench

Double-buffer controller and write-port arbiter for the frame RAM. It shares frame RAM port A between two pixel writers, with round-robin arbitration, and steers all writes into the back buffer. It swaps front and back buffers only at a frame boundary reported by the read side (RAM control / driver PHY). The read side uses `front_buf_out` as the base-select bit on port B.

---
 rtl/led_display_frame_swap_arbiter.sv | 156 +++++++++++++++
 tb/tb_led_display_frame_swap_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_display_frame_swap_arbiter.sv
// ============================================================================
// led_display_frame_swap_arbiter
//   Frame RAM double-buffer controller with a two-writer port-A arbiter.
//   Optional feature macro: LED_DISPLAY_ARB_FIXED_PRIO_EN (fixed priority).
//   Revision: 1.0
// ============================================================================
`default_nettype none

module led_display_frame_swap_arbiter #(
  parameter int ADDR_W = 10
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              wr0_valid_in,
  output logic              wr0_ready_out,
  input  logic [ADDR_W-1:0] wr0_addr_in,
  input  logic [31:0]       wr0_data_in,
  input  logic              wr1_valid_in,
  output logic              wr1_ready_out,
  input  logic [ADDR_W-1:0] wr1_addr_in,
  input  logic [31:0]       wr1_data_in,
  input  logic              swap_req_in,
  input  logic              frame_done_in,
  output logic              swap_pending_out,
  output logic              swap_done_out,
  output logic              front_buf_out,
  output logic [3:0]        ram_wen_out,
  output logic [31:0]       ram_addr_out,
  output logic [31:0]       ram_data_out
);

  localparam int PAD_W = 32 - ADDR_W - 3;

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SWAP    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        front_q, front_d;
  logic        swap_done_q, swap_done_d;
  logic [3:0]  wen_q, wen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        grant0, grant1;

`ifndef LED_DISPLAY_ARB_FIXED_PRIO_EN
  logic        last_grant_q, last_grant_d;
`endif

  // Grants are only possible in FILL, so the back buffer is frozen otherwise.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == ST_FILL) begin
`ifdef LED_DISPLAY_ARB_FIXED_PRIO_EN
      grant0 = wr0_valid_in;
      grant1 = wr1_valid_in & ~wr0_valid_in;
`else
      grant0 = wr0_valid_in & (~wr1_valid_in | last_grant_q);
      grant1 = wr1_valid_in & (~wr0_valid_in | ~last_grant_q);
`endif
    end
  end

  assign wr0_ready_out = grant0;
  assign wr1_ready_out = grant1;

  // Write datapath: the buffer-select bit is always the inverse of the front.
  always_comb begin
    wen_d  = 4'h0;
    addr_d = addr_q;
    data_d = data_q;
    if (grant0) begin
      wen_d  = 4'hF;
      addr_d = {{PAD_W{1'b0}}, ~front_q, wr0_addr_in, 2'b00};
      data_d = wr0_data_in;
    end else if (grant1) begin
      wen_d  = 4'hF;
      addr_d = {{PAD_W{1'b0}}, ~front_q, wr1_addr_in, 2'b00};
      data_d = wr1_data_in;
    end
  end

`ifndef LED_DISPLAY_ARB_FIXED_PRIO_EN
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant0) begin
      last_grant_d = 1'b0;
    end else if (grant1) begin
      last_grant_d = 1'b1;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    front_d     = front_q;
    swap_done_d = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (swap_req_in) begin
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (frame_done_in) begin
          state_d = ST_SWAP;
        end
      end
      ST_SWAP: begin
        state_d     = ST_FILL;
        front_d     = ~front_q;
        swap_done_d = 1'b1;
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q      <= ST_FILL;
      front_q      <= 1'b0;
      swap_done_q  <= 1'b0;
      wen_q        <= 4'h0;
      addr_q       <= 32'h0;
      data_q       <= 32'h0;
`ifndef LED_DISPLAY_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      front_q      <= front_d;
      swap_done_q  <= swap_done_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
`ifndef LED_DISPLAY_ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign swap_pending_out = (state_q == ST_PENDING) || (state_q == ST_SWAP);
  assign swap_done_out    = swap_done_q;
  assign front_buf_out    = front_q;
  assign ram_wen_out      = wen_q;
  assign ram_addr_out     = addr_q;
  assign ram_data_out     = data_q;

endmodule

`default_nettype wire

// File: tb/tb_led_display_frame_swap_arbiter.sv
// ============================================================================
// tb_led_display_frame_swap_arbiter
//   Directed plus randomized bench against a behavioural buffer/arbiter model.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_led_display_frame_swap_arbiter;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              v0, v1, sr, fd;
  logic [ADDR_W-1:0] a0, a1;
  logic [31:0]       d0, d1;
  logic              r0, r1, pend, done, front;
  logic [3:0]        wen;
  logic [31:0]       raddr, rdata;

  always #5 clk = ~clk;

  led_display_frame_swap_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk_in(clk), .reset_in(rst),
    .wr0_valid_in(v0), .wr0_ready_out(r0), .wr0_addr_in(a0), .wr0_data_in(d0),
    .wr1_valid_in(v1), .wr1_ready_out(r1), .wr1_addr_in(a1), .wr1_data_in(d1),
    .swap_req_in(sr), .frame_done_in(fd),
    .swap_pending_out(pend), .swap_done_out(done), .front_buf_out(front),
    .ram_wen_out(wen), .ram_addr_out(raddr), .ram_data_out(rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: phase 0 = filling, 1 = waiting for frame end, 2 = swapping.
  int          m_phase;
  bit          m_front;
  int          m_lastg;
  logic [3:0]  m_wen;
  logic [31:0] m_addr, m_data;
  bit          m_done;

  int          last_g;
  bit          obs_g0, obs_g1, obs_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int predict_grant(bit pv0, bit pv1);
    if (m_phase != 0) return -1;
    if (pv0 && !pv1) return 0;
    if (pv1 && !pv0) return 1;
    if (!pv0 && !pv1) return -1;
`ifdef LED_DISPLAY_ARB_FIXED_PRIO_EN
    return 0;
`else
    return (m_lastg == 0) ? 1 : 0;
`endif
  endfunction

  task automatic model_reset();
    m_phase = 0; m_front = 0; m_lastg = 1;
    m_wen = 4'h0; m_addr = 32'h0; m_data = 32'h0; m_done = 0;
  endtask

  // One clock: drive, compare at the falling edge, advance the model, cross the edge.
  task automatic step(input bit sv0, input logic [ADDR_W-1:0] sa0, input logic [31:0] sd0,
                      input bit sv1, input logic [ADDR_W-1:0] sa1, input logic [31:0] sd1,
                      input bit ssr, input bit sfd, input bit srst);
    int g;
    int wa;
    v0 = sv0; a0 = sa0; d0 = sd0;
    v1 = sv1; a1 = sa1; d1 = sd1;
    sr = ssr; fd = sfd; rst = srst;
    @(negedge clk);
    g = predict_grant(sv0, sv1);
    check("ready0", {31'b0, r0}, (g == 0) ? 32'd1 : 32'd0);
    check("ready1", {31'b0, r1}, (g == 1) ? 32'd1 : 32'd0);
    check("pending", {31'b0, pend}, (m_phase != 0) ? 32'd1 : 32'd0);
    check("swap_done", {31'b0, done}, {31'b0, m_done});
    check("front", {31'b0, front}, {31'b0, m_front});
    check("wen", {28'b0, wen}, {28'b0, m_wen});
    check("addr", raddr, m_addr);
    check("data", rdata, m_data);
    obs_g0 = r0; obs_g1 = r1; obs_done = done;
    last_g = g;
    if (srst) begin
      model_reset();
    end else begin
      if (g >= 0) begin
        wa     = (g == 0) ? int'(sa0) : int'(sa1);
        m_wen  = 4'hF;
        m_addr = (m_front ? 32'd0 : (32'd1 << (ADDR_W + 2))) + 32'(wa * 4);
        m_data = (g == 0) ? sd0 : sd1;
        m_lastg = g;
      end else begin
        m_wen = 4'h0;
      end
      m_done = 0;
      if (m_phase == 0) begin
        if (ssr) m_phase = 1;
      end else if (m_phase == 1) begin
        if (sfd) m_phase = 2;
      end else begin
        m_phase = 0;
        m_front = !m_front;
        m_done  = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0, 0, 0, 0);
  endtask

  task automatic ctrl(input bit csr, input bit cfd, input bit crst);
    step(0, '0, '0, 0, '0, '0, csr, cfd, crst);
  endtask

  int          gr [4];
  int          exp_gr [4];
  int          ndone;
  bit          cv0, cv1;
  logic [ADDR_W-1:0] ca0, ca1;
  logic [31:0] cd0, cd1;

  initial begin
    v0 = 0; v1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0; sr = 0; fd = 0; rst = 1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state then a single write to word 5 of back buffer 1
    idle(1);
    check("rst_front", {31'b0, front}, 32'd0);
    check("rst_wen", {28'b0, wen}, 32'd0);
    step(1, 10'h005, 32'h11111111, 0, '0, '0, 0, 0, 0);
    check("wr_wen", {28'b0, wen}, 32'h0000000F);
    check("wr_addr", raddr, 32'h00001014);
    check("wr_data", rdata, 32'h11111111);

    // Tie sequence from reset
    ctrl(0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 10'(i), 32'hA0000000 + i, 1, 10'(i + 16), 32'hB0000000 + i, 0, 0, 0);
      gr[i] = obs_g1 ? 1 : (obs_g0 ? 0 : -1);
      check("tie_wen", {28'b0, wen}, 32'h0000000F);
    end
`ifdef LED_DISPLAY_ARB_FIXED_PRIO_EN
    exp_gr = '{0, 0, 0, 0};
`else
    exp_gr = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 4; i++) check("tie_grant", gr[i], exp_gr[i]);

    // Swap with writers pressing throughout PENDING
    ctrl(1, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 10'h001, 32'h1, 1, 10'h002, 32'h2, 0, 0, 0);
    ctrl(0, 1, 0);
    check("swap_front_u", {31'b0, front}, 32'd0);
    idle(1);
    check("swap_front_u1", {31'b0, front}, 32'd1);
    check("swap_done_pulse", {31'b0, done}, 32'd1);
    step(1, 10'h000, 32'hCAFEF00D, 0, '0, '0, 0, 0, 0);
    check("post_swap_addr", raddr, 32'h00000000);

    // Request and frame end together: no swap until the next frame end
    ctrl(1, 1, 0);
    idle(3);
    check("same_cycle_front", {31'b0, front}, 32'd1);
    ctrl(0, 1, 0);
    idle(1);
    check("same_cycle_swap", {31'b0, front}, 32'd0);

    // Reset while in SWAP
    ctrl(1, 0, 0);
    ctrl(0, 1, 0);
    step(1, 10'h003, 32'h3, 0, '0, '0, 0, 0, 1);
    check("rst_swap_front", {31'b0, front}, 32'd0);
    check("rst_swap_pend", {31'b0, pend}, 32'd0);
    check("rst_swap_wen", {28'b0, wen}, 32'd0);

    // Stray frame end, then a duplicated swap request
    step(1, 10'h003, 32'h33, 0, '0, '0, 0, 1, 0);
    check("stray_fd_front", {31'b0, front}, 32'd0);
    check("stray_fd_addr", raddr, 32'h0000100C);
    ctrl(1, 0, 0);
    ctrl(1, 0, 0);
    idle(2);
    ctrl(0, 1, 0);
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      if (obs_done) ndone++;
    end
    check("dup_req_swaps", ndone, 32'd1);
    check("dup_req_front", {31'b0, front}, 32'd1);

    // Randomized traffic; a stalled writer holds its request stable
    cv0 = 0; cv1 = 0; ca0 = '0; ca1 = '0; cd0 = '0; cd1 = '0; last_g = -1;
    for (int i = 0; i < 800; i++) begin
      if (!(cv0 && last_g != 0)) begin
        cv0 = ($urandom % 3) != 0; ca0 = 10'($urandom); cd0 = $urandom;
      end
      if (!(cv1 && last_g != 1)) begin
        cv1 = ($urandom % 3) != 0; ca1 = 10'($urandom); cd1 = $urandom;
      end
      step(cv0, ca0, cd0, cv1, ca1, cd1,
           ($urandom % 12) == 0, ($urandom % 6) == 0, ($urandom % 300) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
